// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared limits and lane reduction helper for the gp12t3v3 AND/NAND pipeline macro.
package gf180mcu_osu_sc_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_N     = 8;
  localparam int MAX_DEPTH = 8;

  // Operand arrives zero-extended to MAX_N; only the low n bits take part in the AND.
  function automatic logic lane_reduce(input logic [MAX_N-1:0] bits, input int n, input logic inv);
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) acc = acc & bits[i];
    end
    return acc ^ inv;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__pipe_stage.sv
// One elastic valid/ready register stage; ready propagates combinationally from downstream.
module gf180mcu_osu_sc_gp12t3v3__pipe_stage
  import gf180mcu_osu_sc_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  input  logic         i_adv_dn,
  output logic         o_adv,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic         r_v;
  logic [W-1:0] r_data;
  logic         w_adv;

  // An empty stage can always take a word, which is what lets bubbles collapse.
  assign w_adv = !r_v || i_adv_dn;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v    <= 1'b0;
      r_data <= '0;
    end else if (w_adv) begin
      r_v <= i_vld;
      if (i_vld) r_data <= i_data;
    end
  end

  assign o_adv  = w_adv;
  assign o_vld  = r_v;
  assign o_data = r_data;

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__andn_pipe.sv
// W lanes of N-input AND/NAND feeding a DEPTH-stage elastic pipeline (DEPTH=0 is purely combinational).
module gf180mcu_osu_sc_gp12t3v3__andn_pipe
  import gf180mcu_osu_sc_pkg::*;
#(
  parameter int W     = 1,
  parameter int N     = 2,
  parameter int DEPTH = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] A,
  input  logic           INV,
  input  logic           VLD_I,
  output logic           RDY_O,
  output logic [W-1:0]   Y,
  output logic           VLD_O,
  input  logic           RDY_I
);

  if (W < 1 || W > MAX_W || N < 2 || N > MAX_N || DEPTH < 0 || DEPTH > MAX_DEPTH) begin : gen_bad_params
    $fatal(1, "andn_pipe: illegal parameters W=%0d N=%0d DEPTH=%0d", W, N, DEPTH);
  end

  logic [W-1:0] w_r;

  for (genvar gi = 0; gi < W; gi++) begin : gen_lane
    logic [MAX_N-1:0] w_bits;
    assign w_bits  = MAX_N'(A[gi*N +: N]);
    assign w_r[gi] = lane_reduce(w_bits, N, INV);
  end

  if (DEPTH == 0) begin : gen_comb
    assign Y     = w_r;
    assign VLD_O = VLD_I;
    assign RDY_O = RDY_I;
  end else begin : gen_pipe
    logic [W-1:0] w_data [DEPTH+1];
    logic [DEPTH:0] w_vld;

    assign w_data[0] = w_r;
    assign w_vld[0]  = VLD_I;

    // Each stage keeps its own ready net so the backward chain is not one self-referencing vector.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stage
      logic w_adv;
      logic w_adv_dn;

      if (gi == DEPTH - 1) begin : gen_last
        assign w_adv_dn = RDY_I;
      end else begin : gen_mid
        assign w_adv_dn = gen_stage[gi+1].w_adv;
      end

      gf180mcu_osu_sc_gp12t3v3__pipe_stage #(.W(W)) u_stage (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_vld    (w_vld[gi]),
        .i_data   (w_data[gi]),
        .i_adv_dn (w_adv_dn),
        .o_adv    (w_adv),
        .o_vld    (w_vld[gi+1]),
        .o_data   (w_data[gi+1])
      );
    end

    assign RDY_O = gen_stage[0].w_adv;
    assign Y     = w_data[DEPTH];
    assign VLD_O = w_vld[DEPTH];
  end

  specify
    (CLK *> Y) = 0;
    (CLK => VLD_O) = 0;
    (RDY_I => RDY_O) = 0;
    (A *> Y) = 0;
    (INV *> Y) = 0;
  endspecify

endmodule
